// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Next-PC predictor for the pipelined 16-bit datapath. A direct-mapped branch
// target buffer (BTB) supplies targets; a pattern history table (PHT) of 2-bit
// saturating counters supplies direction for conditional branches. The PHT is
// indexed by the low PC bits (bimodal, MODE = 0) or by the low PC bits XOR the
// global history register (gshare, MODE = 1).
//
// Ports
//   clk, reset         : clock, asynchronous active-high reset
//   if_pc, lookup_en   : fetch PC; lookup_en qualifies the hit statistic only
//   pred_hit           : BTB entry valid with matching tag
//   pred_taken         : predicted taken
//   pred_target        : predicted next PC (target or if_pc+1)
//   ghr                : current global history, carried down the pipe to ID
//   upd_*              : branch/jump resolution from ID (pc, kind, outcome,
//                        the prediction that was made and its ghr snapshot)
//   mispredict         : flush IF/ID and redirect fetch to redirect_pc
//   redirect_pc        : correct next PC of the resolving instruction
//   hit_count          : saturating count of advancing fetches that hit
//   mispredict_count   : saturating count of mispredicted resolutions
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = WORD_SIZE - INDEX_BITS,
  parameter int MODE       = 0
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [WORD_SIZE-1:0]  if_pc,
  input  logic                  lookup_en,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [WORD_SIZE-1:0]  pred_target,
  output logic [INDEX_BITS-1:0] ghr,

  input  logic                  upd_valid,
  input  logic [WORD_SIZE-1:0]  upd_pc,
  input  logic                  upd_is_branch,
  input  logic                  upd_taken,
  input  logic [WORD_SIZE-1:0]  upd_target,
  input  logic                  upd_pred_taken,
  input  logic [WORD_SIZE-1:0]  upd_pred_target,
  input  logic [INDEX_BITS-1:0] upd_ghr,

  output logic                  mispredict,
  output logic [WORD_SIZE-1:0]  redirect_pc,
  output logic [WORD_SIZE-1:0]  hit_count,
  output logic [WORD_SIZE-1:0]  mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [WORD_SIZE-1:0] ONE_W = WORD_SIZE'(1);
  localparam logic [1:0] PHT_RESET = 2'b01;  // weakly not-taken

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // 2-bit saturating direction counter step.
  function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != 2'b11) res = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'd1;
    end
    return res;
  endfunction

  // Statistics counter that sticks at all-ones instead of wrapping.
  function automatic logic [WORD_SIZE-1:0] stat_next(input logic [WORD_SIZE-1:0] cnt,
                                                     input logic inc);
    logic [WORD_SIZE-1:0] res;
    res = cnt;
    if (inc && (cnt != {WORD_SIZE{1'b1}})) res = cnt + ONE_W;
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ENTRIES-1:0]    valid_q,  valid_d;
  logic [ENTRIES-1:0]    uncond_q, uncond_d;
  logic [1:0]            pht_q [ENTRIES];
  logic [1:0]            pht_d [ENTRIES];
  logic [INDEX_BITS-1:0] ghr_q,      ghr_d;
  logic [WORD_SIZE-1:0]  hit_cnt_q,  hit_cnt_d;
  logic [WORD_SIZE-1:0]  misp_cnt_q, misp_cnt_d;

  // Tag/target storage carries no reset: an entry is only observed through
  // its valid bit, which is cleared by reset.
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0]  target_q [ENTRIES];

  // -------------------------------------------------------------------------
  // Lookup (IF, combinational)
  // -------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] lk_idx;
  logic [INDEX_BITS-1:0] lk_pht_idx;
  logic [TAG_BITS-1:0]   lk_tag;

  assign lk_idx     = if_pc[INDEX_BITS-1:0];
  assign lk_tag     = if_pc[WORD_SIZE-1:INDEX_BITS];
  assign lk_pht_idx = (MODE == 1) ? (lk_idx ^ ghr_q) : lk_idx;

  // Jumps are always taken once the BTB knows them; branches ask the PHT.
  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && (uncond_q[lk_idx] || pht_q[lk_pht_idx][1]);
  assign pred_target = pred_taken ? target_q[lk_idx] : (if_pc + ONE_W);
  assign ghr         = ghr_q;

  // -------------------------------------------------------------------------
  // Resolution (ID, combinational)
  // -------------------------------------------------------------------------
  // A target mismatch only matters when the instruction was actually taken.
  assign mispredict  = upd_valid &&
                       ((upd_pred_taken != upd_taken) ||
                        (upd_taken && (upd_pred_target != upd_target)));
  assign redirect_pc = (upd_valid && upd_taken) ? upd_target : (upd_pc + ONE_W);

  // -------------------------------------------------------------------------
  // Update next-state
  // -------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] up_idx;
  logic [INDEX_BITS-1:0] up_pht_idx;
  logic [TAG_BITS-1:0]   up_tag;
  logic                  btb_we;
  logic                  pht_we;

  assign up_idx     = upd_pc[INDEX_BITS-1:0];
  assign up_tag     = upd_pc[WORD_SIZE-1:INDEX_BITS];
  // Train the counter that was consulted at fetch, i.e. with the fetch-time ghr.
  assign up_pht_idx = (MODE == 1) ? (up_idx ^ upd_ghr) : up_idx;

  // Only taken outcomes allocate; not-taken branches leave the BTB untouched.
  assign btb_we = upd_valid && upd_taken;
  assign pht_we = upd_valid && upd_is_branch;

  always_comb begin
    valid_d    = valid_q;
    uncond_d   = uncond_q;
    pht_d      = pht_q;
    ghr_d      = ghr_q;
    hit_cnt_d  = stat_next(hit_cnt_q, lookup_en && pred_hit);
    misp_cnt_d = stat_next(misp_cnt_q, mispredict);

    if (btb_we) begin
      valid_d[up_idx]  = 1'b1;
      uncond_d[up_idx] = !upd_is_branch;
    end

    if (pht_we) begin
      pht_d[up_pht_idx] = pht_next(pht_q[up_pht_idx], upd_taken);
      // Rebuilding from the fetch snapshot discards wrong-path history.
      ghr_d = {upd_ghr[INDEX_BITS-2:0], upd_taken};
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      uncond_q   <= '0;
      ghr_q      <= '0;
      hit_cnt_q  <= '0;
      misp_cnt_q <= '0;
      for (int k = 0; k < ENTRIES; k++) pht_q[k] <= PHT_RESET;
    end else begin
      valid_q    <= valid_d;
      uncond_q   <= uncond_d;
      ghr_q      <= ghr_d;
      hit_cnt_q  <= hit_cnt_d;
      misp_cnt_q <= misp_cnt_d;
      pht_q      <= pht_d;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_we) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target;
    end
  end

  assign hit_count        = hit_cnt_q;
  assign mispredict_count = misp_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] if_pc;
  logic        lookup_en;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_is_branch;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_pred_taken;
  logic [15:0] upd_pred_target;
  logic [5:0]  upd_ghr;

  // MODE 0 (bimodal) instance outputs
  logic        d0_hit, d0_taken, d0_misp;
  logic [15:0] d0_target, d0_redirect, d0_hcnt, d0_mcnt;
  logic [5:0]  d0_ghr;
  // MODE 1 (gshare) instance outputs
  logic        d1_hit, d1_taken, d1_misp;
  logic [15:0] d1_target, d1_redirect, d1_hcnt, d1_mcnt;
  logic [5:0]  d1_ghr;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  branch_predictor #(.WORD_SIZE(16), .INDEX_BITS(6), .MODE(0)) dut0 (
    .clk(clk), .reset(reset),
    .if_pc(if_pc), .lookup_en(lookup_en),
    .pred_hit(d0_hit), .pred_taken(d0_taken), .pred_target(d0_target), .ghr(d0_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
    .mispredict(d0_misp), .redirect_pc(d0_redirect),
    .hit_count(d0_hcnt), .mispredict_count(d0_mcnt)
  );

  branch_predictor #(.WORD_SIZE(16), .INDEX_BITS(6), .MODE(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_pc(if_pc), .lookup_en(lookup_en),
    .pred_hit(d1_hit), .pred_taken(d1_taken), .pred_target(d1_target), .ghr(d1_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
    .mispredict(d1_misp), .redirect_pc(d1_redirect),
    .hit_count(d1_hcnt), .mispredict_count(d1_mcnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    lookup_en       = 1'b0;
    upd_valid       = 1'b0;
    upd_pc          = 16'h0000;
    upd_is_branch   = 1'b0;
    upd_taken       = 1'b0;
    upd_target      = 16'h0000;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 16'h0000;
    upd_ghr         = 6'd0;
  endtask

  task automatic resolve(input logic [15:0] pc, input logic is_br, input logic tk,
                         input logic [15:0] tgt, input logic ptk, input logic [15:0] ptgt,
                         input logic [5:0] g);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_is_branch   = is_br;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    upd_ghr         = g;
  endtask

  initial begin
    reset = 1'b1;
    if_pc = 16'h0000;
    idle();
    repeat (2) @(negedge clk);

    // Reset state
    reset = 1'b0;
    if_pc = 16'h0010;
    #1;
    chk("rst_hit",    16'(d0_hit), 16'h0000);
    chk("rst_taken",  16'(d0_taken), 16'h0000);
    chk("rst_target", d0_target, 16'h0011);
    chk("rst_ghr",    16'(d1_ghr), 16'h0000);
    chk("rst_hcnt",   d0_hcnt, 16'h0000);
    chk("rst_mcnt",   d0_mcnt, 16'h0000);
    chk("rst_misp",   16'(d0_misp), 16'h0000);

    // Cold taken branch at 0x0010 -> 0x0020
    @(negedge clk); idle();
    resolve(16'h0010, 1'b1, 1'b1, 16'h0020, 1'b0, 16'h0011, 6'd0);
    #1;
    chk("cold_misp",     16'(d0_misp), 16'h0001);
    chk("cold_redirect", d0_redirect, 16'h0020);

    @(negedge clk); idle();
    if_pc = 16'h0010; lookup_en = 1'b1;
    #1;
    chk("alloc_hit",    16'(d0_hit), 16'h0001);
    chk("alloc_taken",  16'(d0_taken), 16'h0001);
    chk("alloc_target", d0_target, 16'h0020);
    chk("alloc_mcnt",   d0_mcnt, 16'h0001);
    chk("gs_hit",       16'(d1_hit), 16'h0001);
    chk("gs_taken",     16'(d1_taken), 16'h0000);  // ghr=1 selects idx 17, still weak NT
    chk("gs_ghr1",      16'(d1_ghr), 16'h0001);

    @(negedge clk); idle();
    #1;
    chk("hcnt_1", d0_hcnt, 16'h0001);

    // Three not-taken resolves, each predicted taken
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); idle();
      resolve(16'h0010, 1'b1, 1'b0, 16'h0020, 1'b1, 16'h0020, 6'd0);
      #1;
      chk("nt_misp",     16'(d0_misp), 16'h0001);
      chk("nt_redirect", d0_redirect, 16'h0011);
    end

    @(negedge clk); idle();
    if_pc = 16'h0010;
    #1;
    chk("sat0_hit",    16'(d0_hit), 16'h0001);
    chk("sat0_taken",  16'(d0_taken), 16'h0000);
    chk("sat0_target", d0_target, 16'h0011);
    chk("sat0_mcnt",   d0_mcnt, 16'h0004);

    // Fourth not-taken, correctly predicted; counter must stay at 0
    @(negedge clk); idle();
    resolve(16'h0010, 1'b1, 1'b0, 16'h0020, 1'b0, 16'h0011, 6'd0);
    #1;
    chk("nt4_misp",     16'(d0_misp), 16'h0000);
    chk("nt4_redirect", d0_redirect, 16'h0011);

    // One taken: 0 -> 1 keeps predicting not-taken (would be 3 if it wrapped)
    @(negedge clk); idle();
    resolve(16'h0010, 1'b1, 1'b1, 16'h0020, 1'b0, 16'h0011, 6'd0);
    #1;
    chk("tk_misp", 16'(d0_misp), 16'h0001);

    @(negedge clk); idle();
    if_pc = 16'h0010;
    #1;
    chk("sat_hold_taken", 16'(d0_taken), 16'h0000);
    chk("sat_hold_mcnt",  d0_mcnt, 16'h0005);

    // Aliasing: 0x0050 shares index 16 with 0x0010
    @(negedge clk); idle();
    if_pc = 16'h0050; lookup_en = 1'b1;
    #1;
    chk("alias_hit",    16'(d0_hit), 16'h0000);
    chk("alias_target", d0_target, 16'h0051);

    // Wrap at 0xFFFF, no update in flight
    @(negedge clk); idle();
    if_pc = 16'hFFFF; upd_pc = 16'hFFFF;
    #1;
    chk("wrap_target",   d0_target, 16'h0000);
    chk("wrap_redirect", d0_redirect, 16'h0000);
    chk("wrap_misp",     16'(d0_misp), 16'h0000);
    chk("alias_hcnt",    d0_hcnt, 16'h0001);

    // JMP 0xFFFF -> 0x0000
    @(negedge clk); idle();
    resolve(16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 6'd0);
    #1;
    chk("jmp_misp",     16'(d0_misp), 16'h0001);
    chk("jmp_redirect", d0_redirect, 16'h0000);

    @(negedge clk); idle();
    if_pc = 16'hFFFF; lookup_en = 1'b1;
    #1;
    chk("jmp_hit",    16'(d0_hit), 16'h0001);
    chk("jmp_taken",  16'(d0_taken), 16'h0001);  // uncond overrides weak-NT counter
    chk("jmp_target", d0_target, 16'h0000);
    chk("jmp_ghr",    16'(d1_ghr), 16'h0001);    // jumps leave history alone
    chk("jmp_mcnt",   d0_mcnt, 16'h0006);

    // Right direction, wrong target
    @(negedge clk); idle();
    resolve(16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h1234, 6'd0);
    #1;
    chk("badtgt_misp", 16'(d0_misp), 16'h0001);
    chk("jmp_hcnt",    d0_hcnt, 16'h0002);

    // Fully correct prediction
    @(negedge clk); idle();
    resolve(16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000, 6'd0);
    #1;
    chk("good_misp", 16'(d0_misp), 16'h0000);
    chk("good_mcnt", d0_mcnt, 16'h0007);

    // Asynchronous reset mid-stream, between clock edges
    @(negedge clk); idle();
    if_pc = 16'hFFFF;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_hit",    16'(d0_hit), 16'h0000);
    chk("arst_taken",  16'(d0_taken), 16'h0000);
    chk("arst_target", d0_target, 16'h0000);
    chk("arst_hcnt",   d0_hcnt, 16'h0000);
    chk("arst_mcnt",   d0_mcnt, 16'h0000);
    chk("arst_ghr",    16'(d1_ghr), 16'h0000);

    // Update while reset is high must be dropped
    resolve(16'h0030, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0031, 6'd0);
    @(negedge clk);
    @(negedge clk); idle();
    reset = 1'b0;
    if_pc = 16'h0030;
    #1;
    chk("rstupd_hit",  16'(d0_hit), 16'h0000);
    chk("rstupd_ghr",  16'(d1_ghr), 16'h0000);

    // Gshare: allocate 0x000F, then T/NT/T at 0x0008 with carried history
    @(negedge clk); idle();
    resolve(16'h000F, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0010, 6'd0);
    @(negedge clk); idle();
    resolve(16'h0008, 1'b1, 1'b1, 16'h0200, 1'b0, 16'h0009, 6'd0);
    @(negedge clk); idle();
    resolve(16'h0008, 1'b1, 1'b0, 16'h0200, 1'b1, 16'h0200, 6'd1);
    @(negedge clk); idle();
    resolve(16'h0008, 1'b1, 1'b1, 16'h0200, 0, 16'h0009, 6'd2);
    @(negedge clk); idle();
    if_pc = 16'h000F;
    #1;
    chk("gs_ghr101",   16'(d1_ghr), 16'h0005);
    chk("bm_ghr101",   16'(d0_ghr), 16'h0005);
    chk("gs_f_taken",  16'(d1_taken), 16'h0001);  // 0x0F ^ 5 = idx 10, trained taken
    chk("gs_f_target", d1_target, 16'h0100);

    @(negedge clk); idle();
    if_pc = 16'h0008;
    #1;
    chk("gs_8_hit",    16'(d1_hit), 16'h0001);
    chk("gs_8_taken",  16'(d1_taken), 16'h0000);  // 0x08 ^ 5 = idx 13, untouched
    chk("gs_8_target", d1_target, 16'h0009);
    chk("bm_8_taken",  16'(d0_taken), 16'h0001);  // idx 8: 1->2->1->2
    chk("bm_8_target", d0_target, 16'h0200);

    // Same-cycle update and lookup of 0x0030: no bypass
    @(negedge clk); idle();
    if_pc = 16'h0030;
    resolve(16'h0030, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0031, 6'd0);
    #1;
    chk("same_hit",    16'(d0_hit), 16'h0000);
    chk("same_target", d0_target, 16'h0031);

    @(negedge clk); idle();
    if_pc = 16'h0030;
    #1;
    chk("next_hit",    16'(d0_hit), 16'h0001);
    chk("next_taken",  16'(d0_taken), 16'h0001);
    chk("next_target", d0_target, 16'h0040);
    chk("next_gs_hit", 16'(d1_hit), 16'h0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
